// File: rtl/tx_frame_sequencer_pkg.sv
// Shared types and defaults for the tx frame sequencer.
//   tx_seq_state_e : sequencer FSM states
//   tx_seq_dbg_t   : debug view of FSM state and message continuation flag
//   K/P/PAD defaults for a standard RS(255,223) codeblock
package tx_frame_sequencer_pkg;

    localparam int          K_BYTES_DEF  = 223;
    localparam int          P_BYTES_DEF  = 32;
    localparam logic [7:0]  PAD_BYTE_DEF = 8'h00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PAD    = 2'd2,
        PARITY = 2'd3
    } tx_seq_state_e;

    typedef struct packed {
        tx_seq_state_e state;
        logic          msg_open;
    } tx_seq_dbg_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tx_frame_sequencer_if.sv
// Byte streams around the tx frame sequencer.
//   s_data_*  : message bytes from the message source
//   s_par_*   : RS parity bytes from the parity generator
//   m_axis_*  : codeblock bytes towards the scrambler
// Handshake: a byte moves on every clock edge where valid && ready. A source
// keeps valid and its payload stable until accepted; ready never depends on
// the valid it qualifies.
// Modports: master = the sequencer, slave = its environment.
interface tx_frame_sequencer_if;

    logic       s_data_valid;
    logic       s_data_ready;
    logic [7:0] s_data;
    logic       s_data_last;

    logic       s_par_valid;
    logic       s_par_ready;
    logic [7:0] s_par_data;
    logic       s_par_last;

    logic       m_axis_valid;
    logic       m_axis_ready;
    logic [7:0] m_axis_data;
    logic       m_axis_sop;
    logic       m_axis_last;
    logic       m_axis_is_parity;

    modport master (
        input  s_data_valid, s_data, s_data_last,
        output s_data_ready,
        input  s_par_valid, s_par_data, s_par_last,
        output s_par_ready,
        output m_axis_valid, m_axis_data, m_axis_sop, m_axis_last, m_axis_is_parity,
        input  m_axis_ready
    );

    modport slave (
        output s_data_valid, s_data, s_data_last,
        input  s_data_ready,
        output s_par_valid, s_par_data, s_par_last,
        input  s_par_ready,
        input  m_axis_valid, m_axis_data, m_axis_sop, m_axis_last, m_axis_is_parity,
        output m_axis_ready
    );

endinterface

// File: rtl/tx_frame_sequencer_out_reg.sv
// One-deep valid/ready output register for codeblock bytes.
// Ports:
//   clk, rst        : clock, async active-high reset
//   i_push          : load payload (only asserted by the caller when o_ld)
//   i_data/i_sop/i_last/i_is_parity : payload to load
//   i_ready         : downstream ready
//   o_ld            : register can take a new byte this cycle
//   o_valid/o_data/o_sop/o_last/o_is_parity : registered outputs
module tx_out_reg (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  logic [7:0] i_data,
    input  logic       i_sop,
    input  logic       i_last,
    input  logic       i_is_parity,
    input  logic       i_ready,
    output logic       o_ld,
    output logic       o_valid,
    output logic [7:0] o_data,
    output logic       o_sop,
    output logic       o_last,
    output logic       o_is_parity
);

    logic       r_valid;
    logic [7:0] r_data;
    logic       r_sop;
    logic       r_last;
    logic       r_is_parity;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_data      <= 8'h00;
            r_sop       <= 1'b0;
            r_last      <= 1'b0;
            r_is_parity <= 1'b0;
        end else if (i_push) begin
            r_valid     <= 1'b1;
            r_data      <= i_data;
            r_sop       <= i_sop;
            r_last      <= i_last;
            r_is_parity <= i_is_parity;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Payload only changes on a push, and pushes only happen when empty or
    // draining, so a stalled byte stays put.
    assign o_ld        = !r_valid || i_ready;
    assign o_valid     = r_valid;
    assign o_data      = r_data;
    assign o_sop       = r_sop;
    assign o_last      = r_last;
    assign o_is_parity = r_is_parity;

endmodule

// File: rtl/tx_frame_sequencer.sv
// Builds fixed-length codeblocks: K message bytes (short messages padded with
// PAD_BYTE) followed by P parity bytes, tagged with sop/last/is_parity.
// Ports:
//   clk, rst     : clock, async active-high reset
//   bus          : tx_frame_sequencer_if.master (message in, parity in, codeblock out)
//   err_clr      : clears err_par_len
//   err_par_len  : sticky, s_par_last not aligned with the P-th parity byte
//   busy         : codeblock in progress or output byte pending
//   dbg          : FSM state and message-continuation flag
module tx_frame_sequencer
    import tx_frame_sequencer_pkg::*;
#(
    parameter int         K_BYTES  = K_BYTES_DEF,
    parameter int         P_BYTES  = P_BYTES_DEF,
    parameter logic [7:0] PAD_BYTE = PAD_BYTE_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    tx_frame_sequencer_if.master        bus,
    input  logic                        err_clr,
    output logic                        err_par_len,
    output logic                        busy,
    output tx_seq_dbg_t                 dbg
);

    localparam int MAX_KP = max_int(K_BYTES, P_BYTES);
    localparam int CNT_W  = (MAX_KP > 2) ? $clog2(MAX_KP) : 1;
    localparam logic [CNT_W-1:0] K_LAST = CNT_W'(K_BYTES - 1);
    localparam logic [CNT_W-1:0] P_LAST = CNT_W'(P_BYTES - 1);

    tx_seq_state_e    r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_msg_open;
    logic             r_err;

    logic       w_ld;
    logic       w_push;
    logic [7:0] w_data;
    logic       w_sop;
    logic       w_last;
    logic       w_is_par;
    logic       w_err_set;
    logic       w_k_end;
    logic       w_p_end;
    logic       w_m_valid;
    logic [7:0] w_m_data;
    logic       w_m_sop;
    logic       w_m_last;
    logic       w_m_is_par;

    assign w_k_end = (r_cnt == K_LAST);
    assign w_p_end = (r_cnt == P_LAST);

    // Byte selection for the output register; a push happens only when the
    // register can load and the current phase has a byte to offer.
    always_comb begin
        w_push    = 1'b0;
        w_data    = 8'h00;
        w_sop     = 1'b0;
        w_last    = 1'b0;
        w_is_par  = 1'b0;
        w_err_set = 1'b0;
        unique case (r_state)
            IDLE, DATA: begin
                if (bus.s_data_valid && w_ld) begin
                    w_push = 1'b1;
                    w_data = bus.s_data;
                    w_sop  = (r_state == IDLE);
                end
            end
            PAD: begin
                if (w_ld) begin
                    w_push = 1'b1;
                    w_data = PAD_BYTE;
                end
            end
            PARITY: begin
                if (bus.s_par_valid && w_ld) begin
                    w_push    = 1'b1;
                    w_data    = bus.s_par_data;
                    w_is_par  = 1'b1;
                    w_last    = w_p_end;
                    // The block length is fixed by the counter; a misplaced
                    // s_par_last is only reported.
                    w_err_set = (bus.s_par_last != w_p_end);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_msg_open <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
            if (w_push) begin
                unique case (r_state)
                    IDLE: begin
                        r_cnt <= CNT_W'(1);
                        if (bus.s_data_last) begin
                            r_state    <= PAD;
                            r_msg_open <= 1'b0;
                        end else begin
                            r_state <= DATA;
                        end
                    end
                    DATA: begin
                        if (w_k_end) begin
                            // Message still running past this block: the next
                            // block carries on with data, no padding.
                            r_state    <= PARITY;
                            r_cnt      <= '0;
                            r_msg_open <= !bus.s_data_last;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                            if (bus.s_data_last) begin
                                r_state    <= PAD;
                                r_msg_open <= 1'b0;
                            end
                        end
                    end
                    PAD: begin
                        if (w_k_end) begin
                            r_state <= PARITY;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    PARITY: begin
                        if (w_p_end) begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    tx_out_reg u_out_reg (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_data      (w_data),
        .i_sop       (w_sop),
        .i_last      (w_last),
        .i_is_parity (w_is_par),
        .i_ready     (bus.m_axis_ready),
        .o_ld        (w_ld),
        .o_valid     (w_m_valid),
        .o_data      (w_m_data),
        .o_sop       (w_m_sop),
        .o_last      (w_m_last),
        .o_is_parity (w_m_is_par)
    );

    assign bus.m_axis_valid     = w_m_valid;
    assign bus.m_axis_data      = w_m_data;
    assign bus.m_axis_sop       = w_m_sop;
    assign bus.m_axis_last      = w_m_last;
    assign bus.m_axis_is_parity = w_m_is_par;

    assign bus.s_data_ready = w_ld && ((r_state == IDLE) || (r_state == DATA));
    assign bus.s_par_ready  = w_ld && (r_state == PARITY);

    assign err_par_len  = r_err;
    assign busy         = (r_state != IDLE) || w_m_valid;
    assign dbg.state    = r_state;
    assign dbg.msg_open = r_msg_open;

endmodule
